// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a per-register pending-write scoreboard.
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   rs_name_i       NRD packed read names (port k at [k*W_RD +: W_RD])
//   rs_data_o       NRD packed read data, combinational
//   rs_reserved_o   1 = register on read port k has outstanding writes
//   reserve_i/_name_i/reserve_ok_o  reserve one pending write, ok is combinational
//   wb_i/wb_name_i/wb_data_i        NWB write-back ports, always accepted
//   flush_i         clear every pending counter (data is kept)
module regfile_sb #(
    parameter int unsigned WORD     = 32,
    parameter int unsigned NREG     = 16,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWB      = 2,
    parameter int unsigned CNTW     = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned W_RD    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*W_RD-1:0]   rs_name_i,
    output logic [NRD*WORD-1:0]   rs_data_o,
    output logic [NRD-1:0]        rs_reserved_o,
    input  logic                  reserve_i,
    input  logic [W_RD-1:0]       reserve_name_i,
    output logic                  reserve_ok_o,
    input  logic [NWB-1:0]        wb_i,
    input  logic [NWB*W_RD-1:0]   wb_name_i,
    input  logic [NWB*WORD-1:0]   wb_data_i,
    input  logic                  flush_i
);

    logic [WORD-1:0] data_q [NREG];
    logic [CNTW-1:0] cnt_q  [NREG];
    logic [CNTW-1:0] cnt_d  [NREG];

    // A saturated counter or the hardwired zero register refuses the reservation.
    assign reserve_ok_o = reserve_i && !flush_i
                       && (cnt_q[reserve_name_i] != '1)
                       && !(ZERO_REG && (reserve_name_i == '0));

    // Next pending count: +1 for an accepted reserve, -1 per write-back hit, floored at 0.
    always_comb begin
        int hit;
        int net;
        hit = 0;
        net = 0;
        for (int r = 0; r < int'(NREG); r++) begin
            hit = 0;
            for (int j = 0; j < int'(NWB); j++) begin
                if (wb_i[j] && (wb_name_i[j*W_RD +: W_RD] == W_RD'(r))) begin
                    hit++;
                end
            end
            net = int'(cnt_q[r]) - hit;
            if (reserve_ok_o && (reserve_name_i == W_RD'(r))) begin
                net++;
            end
            if (net < 0) begin
                net = 0;
            end
            cnt_d[r] = CNTW'(net);
            if (flush_i || (ZERO_REG && (r == 0))) begin
                cnt_d[r] = '0;
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(NREG); r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < int'(NREG); r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Data state; later ports are applied last so the highest-index port wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(NREG); r++) begin
                data_q[r] <= '0;
            end
        end else begin
            for (int j = 0; j < int'(NWB); j++) begin
                if (wb_i[j] && !(ZERO_REG && (wb_name_i[j*W_RD +: W_RD] == '0))) begin
                    data_q[wb_name_i[j*W_RD +: W_RD]] <= wb_data_i[j*WORD +: WORD];
                end
            end
        end
    end

    // Read ports with optional same-cycle write-back forwarding.
    always_comb begin
        logic [W_RD-1:0] nm;
        logic [WORD-1:0] d;
        int              hit;
        int              left;
        nm            = '0;
        d             = '0;
        hit           = 0;
        left          = 0;
        rs_data_o     = '0;
        rs_reserved_o = '0;
        for (int k = 0; k < int'(NRD); k++) begin
            nm  = rs_name_i[k*W_RD +: W_RD];
            d   = data_q[nm];
            hit = 0;
            for (int j = 0; j < int'(NWB); j++) begin
                if (wb_i[j] && (wb_name_i[j*W_RD +: W_RD] == nm)) begin
                    hit++;
                    d = wb_data_i[j*WORD +: WORD];
                end
            end
            if (BYPASS) begin
                left                 = int'(cnt_q[nm]) - hit;
                rs_data_o[k*WORD +: WORD] = d;
                rs_reserved_o[k]     = (left > 0) && !flush_i;
            end else begin
                rs_data_o[k*WORD +: WORD] = data_q[nm];
                rs_reserved_o[k]     = (cnt_q[nm] != '0);
            end
            if (ZERO_REG && (nm == '0)) begin
                rs_data_o[k*WORD +: WORD] = '0;
                rs_reserved_o[k]     = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb; a BYPASS=1 and a BYPASS=0 instance share stimulus.
module tb_regfile_sb;
    localparam int unsigned WORD = 32;
    localparam int unsigned NREG = 16;
    localparam int unsigned W_RD = 4;
    localparam int unsigned NRD  = 2;
    localparam int unsigned NWB  = 2;
    localparam int unsigned CNTW = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*W_RD-1:0] rs_name;
    logic [NRD*WORD-1:0] rs_data, nb_data;
    logic [NRD-1:0]      rs_reserved, nb_reserved;
    logic                reserve;
    logic [W_RD-1:0]     reserve_name;
    logic                reserve_ok, nb_ok;
    logic [NWB-1:0]      wb;
    logic [NWB*W_RD-1:0] wb_name;
    logic [NWB*WORD-1:0] wb_data;
    logic                flush;
    int                  total = 0;
    int                  bad   = 0;

    always #5 clk = ~clk;

    regfile_sb #(.WORD(WORD), .NREG(NREG), .NRD(NRD), .NWB(NWB), .CNTW(CNTW),
                 .BYPASS(1'b1), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .rs_name_i(rs_name), .rs_data_o(rs_data),
        .rs_reserved_o(rs_reserved), .reserve_i(reserve), .reserve_name_i(reserve_name),
        .reserve_ok_o(reserve_ok), .wb_i(wb), .wb_name_i(wb_name), .wb_data_i(wb_data),
        .flush_i(flush));

    regfile_sb #(.WORD(WORD), .NREG(NREG), .NRD(NRD), .NWB(NWB), .CNTW(CNTW),
                 .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_nb (
        .clk(clk), .rst(rst), .rs_name_i(rs_name), .rs_data_o(nb_data),
        .rs_reserved_o(nb_reserved), .reserve_i(reserve), .reserve_name_i(reserve_name),
        .reserve_ok_o(nb_ok), .wb_i(wb), .wb_name_i(wb_name), .wb_data_i(wb_data),
        .flush_i(flush));

    // Advance to just after the next rising edge, then clear one-shot strobes.
    task automatic cyc();
        @(posedge clk);
        #1;
        reserve = 1'b0;
        wb      = '0;
        flush   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; reserve = 1'b0; reserve_name = '0; wb = '0; wb_name = '0;
        wb_data = '0; flush = 1'b0; rs_name = '0;
        #2;
        for (int r = 0; r < 16; r++) begin
            rs_name = {4'(15 - r), 4'(r)};
            #1;
            total++; if (rs_data !== 64'h0) begin bad++; $display("FAIL reset_data r=%0d got=%h exp=0", r, rs_data); end
            total++; if (rs_reserved !== 2'b00) begin bad++; $display("FAIL reset_reserved r=%0d got=%b exp=00", r, rs_reserved); end
        end
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        cyc();
        reserve = 1'b1; reserve_name = 4'd3; rs_name = {4'd0, 4'd3};
        #2;
        total++; if (reserve_ok !== 1'b1) begin bad++; $display("FAIL byp_reserve_ok got=%b exp=1", reserve_ok); end
        cyc();
        #2;
        total++; if (rs_reserved[0] !== 1'b1) begin bad++; $display("FAIL byp_reserved_c1 got=%b exp=1", rs_reserved[0]); end
        cyc();
        cyc();
        cyc();
        wb = 2'b01; wb_name = {4'd0, 4'd3}; wb_data = {32'h0, 32'hDEADBEEF};
        #2;
        total++; if (rs_data[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL byp_data_c4 got=%h exp=deadbeef", rs_data[31:0]); end
        total++; if (rs_reserved[0] !== 1'b0) begin bad++; $display("FAIL byp_reserved_c4 got=%b exp=0", rs_reserved[0]); end
        total++; if (nb_data[31:0] !== 32'h0) begin bad++; $display("FAIL nobyp_data_c4 got=%h exp=0", nb_data[31:0]); end
        total++; if (nb_reserved[0] !== 1'b1) begin bad++; $display("FAIL nobyp_reserved_c4 got=%b exp=1", nb_reserved[0]); end
        cyc();
        #2;
        total++; if (nb_data[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL nobyp_data_c5 got=%h exp=deadbeef", nb_data[31:0]); end
        total++; if (nb_reserved[0] !== 1'b0) begin bad++; $display("FAIL nobyp_reserved_c5 got=%b exp=0", nb_reserved[0]); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) begin
            cyc();
            reserve = 1'b1; reserve_name = 4'd5;
            #2;
            total++; if (reserve_ok !== (i < 3)) begin bad++; $display("FAIL sat_reserve_ok i=%0d got=%b exp=%b", i, reserve_ok, (i < 3)); end
        end
        rs_name = {4'd5, 4'd0};
        for (int i = 0; i < 3; i++) begin
            cyc();
            wb = 2'b01; wb_name = {4'd0, 4'd5}; wb_data = {32'h0, 32'(i)};
            #2;
            total++; if (rs_reserved[1] !== (i < 2)) begin bad++; $display("FAIL sat_byp_reserved i=%0d got=%b exp=%b", i, rs_reserved[1], (i < 2)); end
            total++; if (nb_reserved[1] !== 1'b1) begin bad++; $display("FAIL sat_nobyp_reserved i=%0d got=%b exp=1", i, nb_reserved[1]); end
        end
        cyc();
        #2;
        total++; if (nb_reserved[1] !== 1'b0) begin bad++; $display("FAIL sat_cleared got=%b exp=0", nb_reserved[1]); end
    endtask

    task automatic test_dual_wb();
        cyc(); reserve = 1'b1; reserve_name = 4'd7;
        cyc(); reserve = 1'b1; reserve_name = 4'd7;
        cyc();
        wb = 2'b11; wb_name = {4'd7, 4'd7}; wb_data = {32'h22, 32'h11}; rs_name = {4'd0, 4'd7};
        #2;
        total++; if (rs_data[31:0] !== 32'h22) begin bad++; $display("FAIL dual_byp_data got=%h exp=22", rs_data[31:0]); end
        total++; if (rs_reserved[0] !== 1'b0) begin bad++; $display("FAIL dual_byp_reserved got=%b exp=0", rs_reserved[0]); end
        cyc();
        #2;
        total++; if (nb_data[31:0] !== 32'h22) begin bad++; $display("FAIL dual_data got=%h exp=22", nb_data[31:0]); end
        total++; if (nb_reserved[0] !== 1'b0) begin bad++; $display("FAIL dual_cnt2 got=%b exp=0", nb_reserved[0]); end
        cyc(); reserve = 1'b1; reserve_name = 4'd7;
        cyc();
        wb = 2'b11; wb_name = {4'd7, 4'd7}; wb_data = {32'h44, 32'h33};
        cyc();
        reserve = 1'b1; reserve_name = 4'd7;
        #2;
        total++; if (nb_reserved[0] !== 1'b0) begin bad++; $display("FAIL dual_nowrap got=%b exp=0", nb_reserved[0]); end
        total++; if (nb_data[31:0] !== 32'h44) begin bad++; $display("FAIL dual_data2 got=%h exp=44", nb_data[31:0]); end
        total++; if (reserve_ok !== 1'b1) begin bad++; $display("FAIL dual_nowrap_ok got=%b exp=1", reserve_ok); end
    endtask

    task automatic test_flush();
        cyc(); reserve = 1'b1; reserve_name = 4'd2;
        cyc(); reserve = 1'b1; reserve_name = 4'd4;
        cyc();
        rs_name = {4'd4, 4'd2};
        #2;
        total++; if (nb_reserved !== 2'b11) begin bad++; $display("FAIL flush_pre got=%b exp=11", nb_reserved); end
        cyc();
        flush = 1'b1; reserve = 1'b1; reserve_name = 4'd6;
        wb = 2'b01; wb_name = {4'd0, 4'd9}; wb_data = {32'h0, 32'h0000CAFE};
        #2;
        total++; if (reserve_ok !== 1'b0) begin bad++; $display("FAIL flush_reserve_ok got=%b exp=0", reserve_ok); end
        cyc();
        #2;
        total++; if (nb_reserved !== 2'b00) begin bad++; $display("FAIL flush_cleared got=%b exp=00", nb_reserved); end
        rs_name = {4'd9, 4'd6};
        #1;
        total++; if (nb_reserved[0] !== 1'b0) begin bad++; $display("FAIL flush_r6 got=%b exp=0", nb_reserved[0]); end
        total++; if (nb_data[63:32] !== 32'h0000CAFE) begin bad++; $display("FAIL flush_wb_data got=%h exp=0000cafe", nb_data[63:32]); end
        rs_name = {4'd7, 4'd7};
        #1;
        total++; if (nb_data[31:0] !== 32'h44) begin bad++; $display("FAIL flush_keeps_data got=%h exp=44", nb_data[31:0]); end
        total++; if (nb_reserved[0] !== 1'b0) begin bad++; $display("FAIL flush_r7 got=%b exp=0", nb_reserved[0]); end
    endtask

    task automatic test_zero();
        cyc();
        wb = 2'b01; wb_name = {4'd0, 4'd0}; wb_data = {32'h0, 32'h55};
        reserve = 1'b1; reserve_name = 4'd0; rs_name = {4'd0, 4'd0};
        #2;
        total++; if (reserve_ok !== 1'b0) begin bad++; $display("FAIL zero_reserve_ok got=%b exp=0", reserve_ok); end
        total++; if (nb_ok !== 1'b0) begin bad++; $display("FAIL zero_reserve_ok_nb got=%b exp=0", nb_ok); end
        total++; if (rs_data[31:0] !== 32'h0) begin bad++; $display("FAIL zero_byp_data got=%h exp=0", rs_data[31:0]); end
        cyc();
        #2;
        total++; if (rs_data !== 64'h0) begin bad++; $display("FAIL zero_data got=%h exp=0", rs_data); end
        total++; if (nb_reserved !== 2'b00) begin bad++; $display("FAIL zero_reserved got=%b exp=00", nb_reserved); end
    endtask

    task automatic test_back_to_back();
        cyc(); reserve = 1'b1; reserve_name = 4'd10;
        cyc();
        reserve = 1'b1; reserve_name = 4'd10;
        wb = 2'b10; wb_name = {4'd10, 4'd0}; wb_data = {32'hA5, 32'h0};
        #2;
        total++; if (reserve_ok !== 1'b1) begin bad++; $display("FAIL b2b_ok got=%b exp=1", reserve_ok); end
        cyc();
        rs_name = {4'd0, 4'd10};
        #2;
        total++; if (nb_reserved[0] !== 1'b1) begin bad++; $display("FAIL b2b_net1 got=%b exp=1", nb_reserved[0]); end
        total++; if (nb_data[31:0] !== 32'hA5) begin bad++; $display("FAIL b2b_data got=%h exp=a5", nb_data[31:0]); end
        cyc();
        wb = 2'b01; wb_name = {4'd0, 4'd10}; wb_data = {32'h0, 32'hB6};
        cyc();
        #2;
        total++; if (nb_reserved[0] !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", nb_reserved[0]); end
        cyc();
        reserve = 1'b1; reserve_name = 4'd10;
        wb = 2'b01; wb_name = {4'd0, 4'd10}; wb_data = {32'h0, 32'hC7};
        cyc();
        #2;
        total++; if (nb_reserved[0] !== 1'b0) begin bad++; $display("FAIL b2b_net0 got=%b exp=0", nb_reserved[0]); end
    endtask

    task automatic test_async_reset();
        cyc();
        wb = 2'b01; wb_name = {4'd0, 4'd11}; wb_data = {32'h0, 32'h77};
        cyc();
        reserve = 1'b1; reserve_name = 4'd11;
        cyc();
        rs_name = {4'd0, 4'd11};
        #1;
        total++; if (nb_data[31:0] !== 32'h77 || nb_reserved[0] !== 1'b1) begin bad++; $display("FAIL arst_pre got=%h/%b exp=77/1", nb_data[31:0], nb_reserved[0]); end
        rst = 1'b1;
        #1;
        total++; if (nb_data[31:0] !== 32'h0 || nb_reserved[0] !== 1'b0) begin bad++; $display("FAIL arst_post got=%h/%b exp=0/0", nb_data[31:0], nb_reserved[0]); end
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_saturate();
        test_dual_wb();
        test_flush();
        test_zero();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with per-register pending-write scoreboard, the next-generation replacement for the single-read/single-writeback register file between the decode and execute stages of the Venus core. Supports NRD read ports, NWB write-back ports, multiple outstanding writes per register via saturating pending counters, optional same-cycle write-back bypass, a hardwired zero register and a global flush for branch squash.

## Interface

- WORD, 32: data width in bits
- NREG, 16: number of architectural registers, power of two, ≥2
- W_RD, $clog2(NREG): register-name width (derived, not overridden)
- NRD, 2: number of read ports, ≥1
- NWB, 2: number of write-back ports, ≥1
- CNTW, 2: pending-counter width; max outstanding writes per register = 2^CNTW−1
- BYPASS, 1: 1 = reads see same-cycle write-back data and counter decrement
- ZERO_REG, 1: 1 = register 0 reads 0, never reserved, writes to it ignored

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rs_name_i  in  NRD*W_RD  read-port register names, port k at bits [k*W_RD +: W_RD]
- rs_data_o  out  NRD*WORD  read data, port k at [k*WORD +: WORD]
- rs_reserved_o  out  NRD  1 = register on port k has pending writes
- reserve_i  in  1  request to reserve one pending write
- reserve_name_i  in  W_RD  register being reserved
- reserve_ok_o  out  1  reservation accepted this cycle
- wb_i  in  NWB  write-back valid per port
- wb_name_i  in  NWB*W_RD  write-back register names
- wb_data_i  in  NWB*WORD  write-back data
- flush_i  in  1  clear all pending counters

## Operation

- State: NREG data registers of WORD bits, NREG counters cnt[r] of CNTW bits.
- Reset (rst=1, async): all data = 0, all cnt = 0. Outputs then: rs_data_o = 0, rs_reserved_o = 0, reserve_ok_o = !flush_i && reserve_i-independent acceptance rule below.
- Reserve: reserve_ok_o = reserve_i && !flush_i && !(cnt[reserve_name_i] == 2^CNTW−1) && !(ZERO_REG && reserve_name_i == 0). Combinational. Accepted reserve increments cnt at next edge. Refused reserve has no effect; decode must stall and retry.
- Write-back: for each port j with wb_i[j], data[wb_name_i[j]] <= wb_data_i[j]; cnt decremented by number of ports targeting that register this cycle, floored at 0 (underflow never wraps). Several ports naming same register: highest-index port's data wins.
- Same-cycle reserve + write-back on one register: net cnt = cnt + 1 − hits, floored at 0.
- Flush: all cnt <= 0 at next edge; write-back data still written; reserve refused. Flush does not alter data.
- Read (combinational): rs_data_o[k] = data[rs_name_i[k]]; rs_reserved_o[k] = cnt[rs_name_i[k]] != 0.
- BYPASS=1: if any wb port targets rs_name_i[k] this cycle, rs_data_o[k] = highest-index matching wb_data_i; rs_reserved_o[k] = (cnt − hits) > 0 (flush forces 0). BYPASS=0: reads reflect registered state only.
- ZERO_REG=1: name 0 reads 0, rs_reserved_o = 0, writes/reserves ignored, cnt[0] stays 0.

## Timing

- Read and reserve_ok_o: 0-cycle combinational from names and current state.
- Write visible to non-bypassed read: 1 cycle after wb_i asserted; bypassed read: same cycle.
- Reservation visible on rs_reserved_o: cycle after reserve_ok_o=1.
- No handshake back-pressure on write-back; wb always accepted.
- rst asserted mid-operation discards all pending counts and data immediately, no partial update at concurrent edge.

## Test plan

- Reset then read all registers on both ports -> rs_data_o = 0, rs_reserved_o = 0.
- Reserve r3 at cycle 0 -> r3 reserved from cycle 1; wb r3=0xDEADBEEF at cycle 4 with BYPASS=1 -> rs_data_o=0xDEADBEEF, rs_reserved_o=0 in cycle 4; BYPASS=0 -> visible cycle 5.
- Reserve r5 three times (CNTW=2) then fourth reserve -> reserve_ok_o=0; three wbs -> reserved clears after third only.
- Both wb ports write r7 (0x11 port 0, 0x22 port 1) with cnt[r7]=2 -> data=0x22, cnt=0; cnt[r7]=1 -> cnt=0, no wrap.
- Reserve r2, r4 then flush_i with concurrent reserve r6 -> all reserved bits 0 next cycle, reserve_ok_o=0 during flush.
- Write 0x55 to r0, reserve r0 with ZERO_REG=1 -> reads 0, reserve_ok_o=0, never reserved.
